// File: rtl/ram_fifo_ctrl.sv
// Show-ahead stream FIFO built around an external simple dual-port RAM with a
// registered read port; a 2-entry output buffer hides the 1-cycle read latency.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_data_w,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data_r
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   wptr, rptr, ram_count;
    logic [ADDR_WIDTH:0]   wptr_n, rptr_n, ram_count_n;
    logic                  rd_pending, pend_n;
    logic [1:0]            buf_count, cnt_n;
    logic [DATA_WIDTH-1:0] buf0, buf1, buf0_n, buf1_n;
    logic [ADDR_WIDTH+1:0] level_n;
    logic [2:0]            occ_after;
    logic                  s_fire, out_fire, issue;

    // Valid/ready: a word moves on a side exactly in the cycle where valid and
    // ready are both high at the clock edge; ready never depends on valid.
    assign ram_count = wptr - rptr;
    assign s_ready   = reset_n && !clear && (ram_count != DEPTH);
    assign s_fire    = s_valid && s_ready;

    assign ram_we     = s_fire;
    assign ram_addr_w = wptr[ADDR_WIDTH-1:0];
    assign ram_data_w = s_data;
    assign ram_addr_r = rptr[ADDR_WIDTH-1:0];

    assign m_valid  = (buf_count != 2'd0);
    assign m_data   = buf0;
    assign out_fire = m_valid && m_ready && !clear;

    // Only issue a RAM read when the word is guaranteed a buffer slot on return.
    assign occ_after = {1'b0, buf_count} + {2'b00, rd_pending} - {2'b00, out_fire};
    assign issue     = !clear && (ram_count != '0) && (occ_after < 3'd2);

    always_comb begin
        buf0_n = buf0;
        buf1_n = buf1;
        cnt_n  = buf_count;
        if (clear) begin
            buf0_n = '0;
            buf1_n = '0;
            cnt_n  = 2'd0;
        end else begin
            case ({out_fire, rd_pending})
                2'b10: begin
                    buf0_n = buf1;
                    cnt_n  = buf_count - 2'd1;
                end
                2'b01: begin
                    if (buf_count == 2'd0) buf0_n = ram_data_r;
                    else                   buf1_n = ram_data_r;
                    cnt_n = buf_count + 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf0_n = ram_data_r;
                    end else begin
                        buf0_n = buf1;
                        buf1_n = ram_data_r;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wptr_n      = clear ? '0 : wptr + {{ADDR_WIDTH{1'b0}}, s_fire};
        rptr_n      = clear ? '0 : rptr + {{ADDR_WIDTH{1'b0}}, issue};
        pend_n      = issue;
        ram_count_n = wptr_n - rptr_n;
        level_n     = {1'b0, ram_count_n}
                    + {{(ADDR_WIDTH+1){1'b0}}, pend_n}
                    + {{ADDR_WIDTH{1'b0}}, cnt_n};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            rd_pending <= 1'b0;
            buf_count  <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            level      <= '0;
        end else begin
            wptr       <= wptr_n;
            rptr       <= rptr_n;
            rd_pending <= pend_n;
            buf_count  <= cnt_n;
            buf0       <= buf0_n;
            buf1       <= buf1_n;
            level      <= level_n;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a 4-deep behavioural RAM: cycle table plus
// streaming, stalled wrap-around and asynchronous reset sequences.
module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_addr_r;
    logic [AW-1:0] ram_addr_w;
    logic [DW-1:0] ram_data_w;
    logic          ram_we;
    logic [DW-1:0] ram_data_r;

    logic [DW-1:0] mem [4];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_pass   = 0;

    typedef struct {
        logic          sv;
        logic [7:0]    sd;
        logic          mr;
        logic          clr;
        logic          e_sr;
        logic          e_we;
        logic          e_mv;
        logic [7:0]    e_md;
        logic [3:0]    e_lvl;
    } vec_t;

    vec_t vecs [$];

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .ram_addr_r (ram_addr_r),
        .ram_addr_w (ram_addr_w),
        .ram_data_w (ram_data_w),
        .ram_we     (ram_we),
        .ram_data_r (ram_data_r)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // registered-read RAM, old data on same-address read/write
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_w] <= ram_data_w;
        ram_data_r <= mem[ram_addr_r];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t v(input logic sv, input logic [7:0] sd, input logic mr,
                               input logic clr, input logic e_sr, input logic e_we,
                               input logic e_mv, input logic [7:0] e_md,
                               input logic [3:0] e_lvl);
        vec_t r;
        r.sv = sv; r.sd = sd; r.mr = mr; r.clr = clr;
        r.e_sr = e_sr; r.e_we = e_we; r.e_mv = e_mv; r.e_md = e_md; r.e_lvl = e_lvl;
        return r;
    endfunction

    // driver + scoreboard for free-running streams
    task automatic run_stream(input int n, input bit stalls, input logic [7:0] base);
        int sent = 0, recv = 0, cyc = 0, first = -1, last = -1, bad = 0;
        bit hold = 1'b0;
        logic [7:0] exp_v;
        exp_q.delete();
        while (recv < n && cyc < 2000) begin
            s_data = base + 8'(sent);
            if (!hold) s_valid = (sent < n) && (stalls ? ($urandom_range(0, 3) != 0) : 1'b1);
            m_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                sent++;
                hold = 1'b0;
            end else begin
                hold = s_valid;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_word", m_data, 32'hffff_ffff);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("stream_data", m_data, exp_v);
                end
                if (!stalls && s_valid && s_ready && level != 4'd3) bad++;
                recv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("stream_word_count", recv, n);
        if (!stalls) begin
            chk("stream_gaps", last - first, n - 1);
            chk("stream_level_steady", bad, 0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("stream_end_level", level, 0);
        chk("stream_end_mvalid", m_valid, 0);
    endtask

    initial begin
        int w;
        reset_n = 1'b0;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_mvalid", m_valid, 0);
        chk("reset_level", level, 0);
        chk("reset_mdata", m_data, 0);
        chk("reset_sready", s_ready, 1);
        chk("reset_we", ram_we, 0);
        chk("reset_addr_r", ram_addr_r, 0);
        chk("reset_addr_w", ram_addr_w, 0);
        @(posedge clk); #1;

        // single word
        vecs.push_back(v(1, 8'h5A, 0, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 1, 8'h5A, 1));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'h5A, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        // fill to capacity, then drain one per cycle
        vecs.push_back(v(1, 8'h01, 0, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h02, 0, 0, 1, 1, 0, 8'h00, 1));
        vecs.push_back(v(1, 8'h03, 0, 0, 1, 1, 0, 8'h00, 2));
        vecs.push_back(v(1, 8'h04, 0, 0, 1, 1, 1, 8'h01, 3));
        vecs.push_back(v(1, 8'h05, 0, 0, 1, 1, 1, 8'h01, 4));
        vecs.push_back(v(1, 8'h06, 0, 0, 1, 1, 1, 8'h01, 5));
        vecs.push_back(v(1, 8'h07, 0, 0, 0, 0, 1, 8'h01, 6));
        vecs.push_back(v(1, 8'h07, 0, 0, 0, 0, 1, 8'h01, 6));
        vecs.push_back(v(0, 8'h00, 1, 0, 0, 0, 1, 8'h01, 6));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'h02, 5));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'h03, 4));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'h04, 3));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'h05, 2));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'h06, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        // clear with a read in flight, then a lone word
        vecs.push_back(v(1, 8'h11, 0, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h12, 0, 0, 1, 1, 0, 8'h00, 1));
        vecs.push_back(v(1, 8'h13, 0, 0, 1, 1, 0, 8'h00, 2));
        vecs.push_back(v(1, 8'h14, 0, 0, 1, 1, 1, 8'h11, 3));
        vecs.push_back(v(1, 8'h15, 0, 0, 1, 1, 1, 8'h11, 4));
        vecs.push_back(v(1, 8'h16, 0, 0, 1, 1, 1, 8'h11, 5));
        vecs.push_back(v(0, 8'h00, 1, 0, 0, 0, 1, 8'h11, 6));
        vecs.push_back(v(1, 8'h77, 1, 1, 0, 0, 1, 8'h12, 5));
        vecs.push_back(v(1, 8'hAA, 0, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            clear   = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d s_ready", i), s_ready, vecs[i].e_sr);
            chk($sformatf("vec%0d ram_we", i), ram_we, vecs[i].e_we);
            chk($sformatf("vec%0d m_valid", i), m_valid, vecs[i].e_mv);
            chk($sformatf("vec%0d level", i), level, vecs[i].e_lvl);
            if (vecs[i].e_mv) chk($sformatf("vec%0d m_data", i), m_data, vecs[i].e_md);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        clear   = 1'b0;

        run_stream(32, 1'b0, 8'h00);
        run_stream(20, 1'b1, 8'h40);

        // asynchronous reset mid-stream, off the clock edge
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = 8'hC0 + 8'(k);
            @(posedge clk); #1;
        end
        s_data = 8'hC3;
        #2;
        chk("pre_reset_we", ram_we, 1);
        chk("pre_reset_mvalid", m_valid, 1);
        chk("pre_reset_level", level, 3);
        reset_n = 1'b0;
        #1;
        chk("in_reset_mvalid", m_valid, 0);
        chk("in_reset_level", level, 0);
        chk("in_reset_we", ram_we, 0);
        @(posedge clk); #3;
        s_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_sready", s_ready, 1);
        chk("post_reset_mvalid", m_valid, 0);
        chk("post_reset_level", level, 0);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        @(posedge clk); #1;
        s_valid = 1'b0;
        w = 0;
        while (!m_valid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("post_reset_latency", w, 2);
        chk("post_reset_word", m_data, 8'h3C);
        chk("post_reset_word_level", level, 1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("post_reset_drained_mvalid", m_valid, 0);
        chk("post_reset_drained_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
